// File: rtl/seg7_counter_driver_if.sv
// seg7_counter_driver_if: 8-bit tile bus carrying io_in (clk, rst, load, en, data) and io_out (segments, dp)
interface seg7_counter_driver_if;
    logic [7:0] io_in;
    logic [7:0] io_out;
    modport master (output io_in, input io_out);
    modport slave (input io_in, output io_out);
endinterface

// File: rtl/seg7_counter_driver.sv
// seg7_counter_driver: prescaled up/down digit counter with load, wrap-toggled dp and registered 7-seg outputs
// io.io_in  = {load data[7:4], en[3], load[2], rst[1], clk[0]}
// io.io_out = {dp[7], segments g..a[6:0]}, inverted when COMMON_ANODE=1
module seg7_counter_driver #(
    parameter int PRESCALE     = 4,
    parameter int MAX_COUNT    = 15,
    parameter int DOWN         = 0,
    parameter int COMMON_ANODE = 0
) (
    seg7_counter_driver_if.slave io
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [3:0] MAXC = 4'(MAX_COUNT);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [6:0] SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic clk, rst, ld, en;
    logic [3:0] din;
    logic [3:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic dp_q, dp_d;
    logic [6:0] seg_q, seg_d;
    logic step, wrap;
    assign {din, en, ld, rst, clk} = io.io_in;
    always_comb begin
        step    = en && presc_q == PLAST;
        wrap    = step && (DOWN != 0 ? count_q == 4'd0 : count_q == MAXC);
        count_d = ld ? (din > MAXC ? MAXC : din)
                : !step ? count_q
                : wrap ? (DOWN != 0 ? MAXC : 4'd0)
                : DOWN != 0 ? count_q - 4'd1 : count_q + 4'd1;
        presc_d = (ld || step) ? '0 : en ? presc_q + 1'b1 : presc_q;
        // load wins over en, so a wrap coinciding with a load must not toggle dp
        dp_d    = dp_q ^ (wrap && !ld);
        seg_d   = SEG[count_q];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            presc_q <= '0;
            dp_q    <= 1'b0;
            seg_q   <= '0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            dp_q    <= dp_d;
            seg_q   <= seg_d;
        end
    end
    assign io.io_out = COMMON_ANODE != 0 ? ~{dp_q, seg_q} : {dp_q, seg_q};
endmodule

// File: doc/seg7_counter_driver.md
Name: seg7_counter_driver

Overview:
- Parametrised successor to the combinational nibble-to-7-segment decoder.
- Adds a synchronous prescaled up/down counter with parallel load, a configurable wrap value (hex or decimal), registered segment outputs and a wrap-toggle indicator on the decimal point.
- Sits directly on the 8-bit io_in/io_out tile interface and drives one 7-segment digit.

Parameters:
- PRESCALE, 4: enabled clock cycles per count step; legal range >= 1.
- MAX_COUNT, 15: wrap value; legal range 1..15. Use 9 for decimal, 15 for hex.
- DOWN, 0: count direction; 0 = up, 1 = down.
- COMMON_ANODE, 0: 1 inverts io_out[7:0] (active-low segments and dp).

Ports:
- io_in[0]  input  1  clock; all state changes on the rising edge.
- io_in[1]  input  1  reset; synchronous, active-high.
- io_in[2]  input  1  load; synchronous parallel load of io_in[7:4].
- io_in[3]  input  1  en; count enable.
- io_in[7:4]  input  4  load data nibble.
- io_out[6:0]  output  7  segments a..g; a is bit 0, g is bit 6; registered.
- io_out[7]  output  1  dp; toggles on each counter wrap; registered.

Behaviour:
- State:
  - count[3:0].
  - presc, sized $clog2(PRESCALE) bits, minimum 1 bit.
  - dp_q.
  - seg_q[6:0].
- Priority each edge: reset > load > en > hold.
- Reset:
  - count=0, presc=0, dp_q=0, seg_q=7'h00 (blank).
  - io_out = 8'h00, or 8'hFF when COMMON_ANODE=1.
  - Reset overrides load/en and aborts any partial prescale interval.
- Load (io_in[2]=1):
  - count <= min(io_in[7:4], MAX_COUNT); presc <= 0.
  - dp_q unchanged.
  - en is ignored in that cycle.
- Count (en=1, load=0):
  - If presc == PRESCALE-1: presc <= 0 and count steps.
  - Otherwise presc <= presc+1.
  - Up step: count==MAX_COUNT -> 0 and dp_q toggles; else count+1.
  - Down step: count==0 -> MAX_COUNT and dp_q toggles; else count-1.
- Hold (en=0, load=0): count, presc and dp_q keep their values. The prescale phase is retained across hold.
- PRESCALE=1: count steps on every enabled cycle.
- Decode:
  - Combinational from count; registered into seg_q every non-reset cycle.
  - Segments lag count by exactly 1 cycle.
  - First post-reset edge shows digit 0 (7'h3F).
- Patterns, bit6..bit0 = g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- io_out[7] = dp_q, XOR COMMON_ANODE. io_out[6:0] = seg_q, XOR {7{COMMON_ANODE}}.
- Count never exceeds MAX_COUNT; no illegal state is reachable.

Test Plan:
- Reset for 2 cycles, then release:
  - During reset io_out=8'h00.
  - 1 cycle after release io_out=8'h3F.
  - io_out stays 8'h3F while en=0.
- Defaults (PRESCALE=4, MAX_COUNT=15, DOWN=0), en=1 for 64 cycles from reset:
  - Digits step 0,1,..,F, one step every 4 cycles; F shows 8'h71.
  - On the F->0 wrap io_out[7] becomes 1 and segments show 8'h3F, i.e. io_out=8'hBF one cycle after the count wraps.
- MAX_COUNT=9, PRESCALE=1, load data 4'hC:
  - count=9; segments 8'h6F next cycle.
  - With en=1, the next step wraps to 0 and dp toggles.
- DOWN=1, PRESCALE=1, MAX_COUNT=9, from reset with en=1:
  - Digits go 0 -> 9 -> 8 in consecutive cycles.
  - dp toggles on the 0->9 transition.
- Simultaneous events:
  - load=1 and en=1 with data 4'h5 -> count=5, presc=0.
  - Reset asserted mid-prescale, with en and load both high -> count=0, blank next cycle.
  - After release the first step occurs exactly PRESCALE enabled cycles later.
- COMMON_ANODE=1, after reset release and one cycle:
  - io_out=8'hC0 (digit 0 inverted, dp off).
  - During reset io_out=8'hFF.
